// File: rtl/onehot_demux.sv
// onehot_demux: registered 1-to-N demux, one-hot route, lowest index wins.
// Optional broadcast of multi-hot selects when ONEHOT_DEMUX_BCAST_EN is defined.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   in_valid_i/in_ready_o   input handshake
//   in_data_i, sel_i        payload and one-hot route select
//   out_valid_o/out_ready_i per-channel output handshake
//   out_data_o              shared registered payload
//   err_o, err_cnt_o        malformed-select pulse and saturating count
module onehot_demux #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [N_OUT-1:0]  sel_i,
  output logic [N_OUT-1:0]  out_valid_o,
  input  logic [N_OUT-1:0]  out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam logic [N_OUT-1:0] ONE = N_OUT'(1);

  logic [N_OUT-1:0]  pend, pend_nxt;
  logic [DATA_W-1:0] data, data_nxt;
  logic              err, err_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              ready;
  logic              accept;
  logic              sel_none;
  logic              sel_multi;
  logic              sel_bad;
  logic [N_OUT-1:0]  sel_low;
  logic [N_OUT-1:0]  route;

  // Free once every pending channel is handshaking this cycle.
  assign ready  = rst_ni & ((pend & ~out_ready_i) == '0);
  assign accept = in_valid_i & ready;

  assign sel_none  = (sel_i == '0);
  // Clearing the lowest set bit leaves something only if multi-hot.
  assign sel_multi = |(sel_i & (sel_i - ONE));
  // Two's-complement isolates the lowest set bit.
  assign sel_low   = sel_i & (~sel_i + ONE);

`ifdef ONEHOT_DEMUX_BCAST_EN
  assign route   = sel_i;
  assign sel_bad = sel_none;
`else
  assign route   = sel_low;
  assign sel_bad = sel_none | sel_multi;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend <= '0;
      data <= '0;
      err  <= 1'b0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      data <= data_nxt;
      err  <= err_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    pend_nxt = pend & ~out_ready_i;
    data_nxt = data;
    err_nxt  = 1'b0;
    cnt_nxt  = cnt;
    if (accept) begin
      pend_nxt = route;
      data_nxt = in_data_i;
      if (sel_bad) begin
        err_nxt = 1'b1;
        if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    in_ready_o  = ready;
    out_valid_o = pend;
    out_data_o  = data;
    err_o       = err;
    err_cnt_o   = cnt;
  end

endmodule

// File: tb/tb_onehot_demux.sv
// tb_onehot_demux: randomized bench against a behavioural model.
// Works with or without ONEHOT_DEMUX_BCAST_EN.
module tb_onehot_demux;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [N-1:0]  sel = '0;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready = '0;
  logic [DW-1:0] out_data;
  logic          err;
  logic [CW-1:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit [N-1:0]  m_pend;
  bit [DW-1:0] m_data;
  bit          m_err;
  int          m_cnt;

  onehot_demux #(.N_OUT(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i(in_data),
    .sel_i(sel),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o(out_data),
    .err_o(err),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_data = '0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  function automatic bit model_ready(input bit [N-1:0] r);
    bit ok = 1;
    for (int k = 0; k < N; k++)
      if (m_pend[k] && !r[k]) ok = 0;
    return ok;
  endfunction

  task automatic check_outputs(input bit [N-1:0] r);
    chk("out_valid", 32'(out_valid), 32'(m_pend));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("err", 32'(err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("in_ready", 32'(in_ready), 32'(model_ready(r)));
  endtask

  // Drive one cycle, check, then advance the model past the next edge.
  task automatic cycle(input bit v, input bit [N-1:0] s,
                       input bit [DW-1:0] d, input bit [N-1:0] r);
    bit acc;
    int ones;
    int low;
    @(negedge clk);
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = r;
    #1;
    check_outputs(r);
    acc = v && model_ready(r);
    for (int k = 0; k < N; k++)
      if (r[k]) m_pend[k] = 0;
    m_err = 0;
    if (acc) begin
      m_data = d;
      ones = $countones(s);
      low = -1;
      for (int k = N - 1; k >= 0; k--)
        if (s[k]) low = k;
      if (ones == 0) begin
        m_pend = '0;
        m_err = 1;
      end else if (ones == 1) begin
        m_pend = s;
      end else begin
`ifdef ONEHOT_DEMUX_BCAST_EN
        m_pend = s;
`else
        m_pend = '0;
        m_pend[low] = 1;
        m_err = 1;
`endif
      end
      if (m_err && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  function automatic bit [N-1:0] rand_sel();
    int c = $urandom_range(0, 9);
    bit [N-1:0] s;
    if (c == 0) s = '0;
    else if (c < 7) begin
      s = '0;
      s[$urandom_range(0, N - 1)] = 1;
    end else s = N'($urandom);
    return s;
  endfunction

  function automatic bit [N-1:0] rand_rdy();
    bit [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  initial begin
    model_reset();
    #12;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic routing, back-to-back
    cycle(1, 4'b0001, 8'h11, 4'hF);
    cycle(1, 4'b0010, 8'h22, 4'hF);
    cycle(1, 4'b0100, 8'h33, 4'hF);
    cycle(1, 4'b1000, 8'h44, 4'hF);
    cycle(0, 4'b0000, 8'h00, 4'hF);

    // backpressure on channel 2
    cycle(1, 4'b0100, 8'hA5, 4'hB);
    cycle(1, 4'b0001, 8'h5A, 4'hB);
    cycle(1, 4'b0001, 8'h5A, 4'hB);
    cycle(1, 4'b0001, 8'h5A, 4'hF);
    cycle(0, 4'b0000, 8'h00, 4'hF);

    // malformed selects
    cycle(1, 4'b0000, 8'h77, 4'hF);
    cycle(0, 4'b0000, 8'h00, 4'hF);
    cycle(1, 4'b0110, 8'h99, 4'h0);
    cycle(0, 4'b0000, 8'h00, 4'h0);
    cycle(0, 4'b0000, 8'h00, 4'hF);

    // broadcast-style drain pattern (single channel without the macro)
    cycle(1, 4'b1011, 8'hB0, 4'h0);
    cycle(0, 4'b0000, 8'h00, 4'b0001);
    cycle(0, 4'b0000, 8'h00, 4'b1000);
    cycle(0, 4'b0000, 8'h00, 4'b0010);
    cycle(0, 4'b0000, 8'h00, 4'hF);

    // counter saturation
    for (int i = 0; i < 10; i++)
      cycle(1, 4'b0000, 8'(i), 4'hF);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 3) != 0), rand_sel(), 8'($urandom),
            rand_rdy());

    // async reset while channel 3 holds 0xC3
    cycle(0, 4'b0000, 8'h00, 4'hF);
    cycle(1, 4'b1000, 8'hC3, 4'h0);
    cycle(0, 4'b0000, 8'h00, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ready", 32'(in_ready), 0);
    chk("arst_cnt", 32'(err_cnt), 0);
    chk("arst_data", 32'(out_data), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 4'b0010, 8'h3C, 4'hF);
    cycle(0, 4'b0000, 8'h00, 4'hF);
    cycle(0, 4'b0000, 8'h00, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onehot_demux.md
Name: onehot_demux

Overview:
- Registered 1-to-N demultiplexer. It takes one valid/ready input stream and routes each beat to one of N output channels.
- The route is chosen by a one-hot select that travels with the beat.
- It is the fan-out counterpart to the team's one-hot N-to-1 muxes: same select encoding and same lowest-index-wins priority, with a single buffered pipeline stage.
- It also flags and counts malformed selects.

Parameters:
- N_OUT, 4, number of output channels (2..16)
- DATA_W, 8, payload width
- CNT_W, 8, width of the select-error counter (saturating)

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  input beat valid
- in_ready_o  output  1  block can accept the input beat
- in_data_i  input  DATA_W  input payload
- sel_i  input  N_OUT  one-hot route select, sampled with the beat
- out_valid_o  output  N_OUT  per-channel valid
- out_ready_i  input  N_OUT  per-channel ready
- out_data_o  output  DATA_W  shared registered payload, meaningful where out_valid_o is set
- err_o  output  1  one-cycle pulse: an accepted beat had a malformed select
- err_cnt_o  output  CNT_W  saturating count of malformed-select beats

Behaviour:
- Reset (rst_ni low, async): pend=0, data register=0, err_o=0, err_cnt_o=0. While rst_ni is low, in_ready_o=0.
- Internal state is one holding register (data) plus a pending mask pend[N_OUT]. out_valid_o = pend.
- States:
  - EMPTY: pend==0.
  - FULL: pend!=0.
- Channel handshake: a channel completes when pend[k] & out_ready_i[k]. done = pend & out_ready_i.
- Output side: pend_next = pend & ~done.
- in_ready_o = (pend & ~out_ready_i)==0. This is combinational and allows full throughput: a new beat loads in the same cycle the last pending channel drains.
- Accept = in_valid_i & in_ready_o. On accept: data register <= in_data_i, and pend <= route(sel_i).
- Select classification:
  - sel_i==0 is "none".
  - Popcount>1 is "multi".
  - Exactly one bit set is valid.
- route(sel_i) without the macro:
  - Valid select: that bit.
  - Multi: the lowest set bit only (lowest index wins).
  - None: 0. The beat is consumed and dropped, no output asserts, and the state stays EMPTY.
- Error reporting: on an accepted beat with none or multi, err_o=1 in the next cycle (registered) and err_cnt_o increments.
- err_cnt_o saturates at all-ones and never wraps.
- Latency: an accepted beat appears on out_valid_o on the next cycle (1-cycle latency).
- Output stability: out_data_o and out_valid_o bits are stable while pend bits are held. A channel bit only drops after its own handshake.
- out_ready_i on channels with pend[k]=0 is ignored.
- No accept when in_valid_i=0, regardless of in_ready_o.
- Reset mid-transfer: pending beats are discarded, outputs clear immediately (async), and the counter clears.

Optional Feature:
- Macro: ONEHOT_DEMUX_BCAST_EN.
- Defined: a multi-hot select broadcasts the beat, so route(sel_i)=sel_i. Each selected channel asserts valid and drops it independently on its own handshake. The register frees only when every selected channel has handshaked, so in_ready_o uses the same formula. Multi-hot is then NOT an error; only sel_i==0 pulses err_o and counts.
- Undefined: lowest-index routing, and multi-hot counts as an error (as above).

Test Plan:
- Basic routing: after reset, all out_ready_i=1; send data 0x11 sel 0001, 0x22 sel 0010, 0x33 sel 0100, 0x44 sel 1000 back-to-back -> one beat per cycle on channels 0,1,2,3 with 1-cycle latency; in_ready_o stays 1; err_cnt_o=0.
- Backpressure: out_ready_i[2]=0, send 0xA5 sel 0100 then 0x5A sel 0001 -> in_ready_o=0 while channel 2 is held; out_data_o stays 0xA5; raise out_ready_i[2] -> 0x5A loads in the same cycle and appears on channel 0 next cycle.
- Malformed select: send sel 0000 data 0x77 -> no out_valid_o, err_o pulses once, err_cnt_o=1.
  - Without the macro, sel 0110 data 0x99 -> delivered on channel 1 only, err_cnt_o=2.
  - With the macro, the same beat -> delivered on channels 1 and 2, err_cnt_o stays 1.
- Broadcast drain (macro on): sel 1011, out_ready_i=0001 then 1000 then 0010 -> out_valid_o goes 1011 -> 1010 -> 0010 -> 0000; in_ready_o is 1 only in the last cycle.
- Saturation: CNT_W=2; send 5 sel=0000 beats -> err_cnt_o reads 1,2,3,3,3; err_o pulses 5 times.
- Async reset: assert rst_ni mid-cycle while channel 3 is pending with data 0xC3 -> out_valid_o=0, in_ready_o=0, err_cnt_o=0 immediately; after release, a new beat routes normally.
